// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : state encoding and owner IDs shared by the RAM arbiter files
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_LDR = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_pick2.sv
// ============================================================================
// arb_pick2 : combinational two-way picker; MEM_ARB_RR_EN selects round-robin
// Rev 1.0
// ============================================================================
`default_nettype none

module arb_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       winner_o,
    output logic       valid_o
);
    import mem_arb_pkg::*;

    assign valid_o = |req_i;

`ifdef MEM_ARB_RR_EN
    // On a tie the requester that was not served last goes next.
    always_comb begin
        winner_o = OWN_CPU;
        if (req_i == 2'b11) begin
            winner_o = (last_i == OWN_LDR) ? OWN_CPU : OWN_LDR;
        end else if (req_i[1]) begin
            winner_o = OWN_LDR;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    assign winner_o = req_i[1] ? OWN_LDR : OWN_CPU;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : CPU/loader req-gnt-done arbiter for one RAM port; MEM_ARB_RR_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cpu_req_i,
    input  logic              cpu_wr_i,
    input  logic [AWIDTH-1:0] cpu_addr_i,
    input  logic [WIDTH-1:0]  cpu_wdata_i,
    output logic              cpu_gnt_o,
    output logic              cpu_done_o,
    output logic [WIDTH-1:0]  cpu_rdata_o,
    input  logic              ldr_req_i,
    input  logic              ldr_wr_i,
    input  logic [AWIDTH-1:0] ldr_addr_i,
    input  logic [WIDTH-1:0]  ldr_wdata_i,
    output logic              ldr_gnt_o,
    output logic              ldr_done_o,
    output logic [WIDTH-1:0]  ldr_rdata_o,
    output logic              ram_rd_o,
    output logic              ram_wr_o,
    output logic [AWIDTH-1:0] ram_addr_o,
    output logic [WIDTH-1:0]  ram_wdata_o,
    input  logic [WIDTH-1:0]  ram_rdata_i
);
    import mem_arb_pkg::*;

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [AWIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [WIDTH-1:0]  ram_wdata_q, ram_wdata_d;
    logic              ram_rd_q, ram_rd_d;
    logic              ram_wr_q, ram_wr_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              ldr_gnt_q, ldr_gnt_d;
    logic              cpu_done_q, cpu_done_d;
    logic              ldr_done_q, ldr_done_d;
    logic [WIDTH-1:0]  cpu_rdata_q, cpu_rdata_d;
    logic [WIDTH-1:0]  ldr_rdata_q, ldr_rdata_d;

    logic              pick_winner;
    logic              pick_valid;
    logic              last_w;

    arb_pick2 u_pick (
        .req_i    ({ldr_req_i, cpu_req_i}),
        .last_i   (last_w),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

`ifdef MEM_ARB_RR_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && pick_valid) begin
            last_d = pick_winner;
        end
    end

    // Starting from "loader served last" lets the CPU win the first tie.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            last_q <= OWN_LDR;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_w = last_q;
`else
    assign last_w = OWN_LDR;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_rd_d    = 1'b0;
        ram_wr_d    = 1'b0;
        cpu_gnt_d   = cpu_gnt_q;
        ldr_gnt_d   = ldr_gnt_q;
        cpu_done_d  = 1'b0;
        ldr_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = ACCESS;
                    owner_d = pick_winner;
                    if (pick_winner == OWN_LDR) begin
                        wr_d        = ldr_wr_i;
                        ram_addr_d  = ldr_addr_i;
                        ram_wdata_d = ldr_wdata_i;
                        ldr_gnt_d   = 1'b1;
                    end else begin
                        wr_d        = cpu_wr_i;
                        ram_addr_d  = cpu_addr_i;
                        ram_wdata_d = cpu_wdata_i;
                        cpu_gnt_d   = 1'b1;
                    end
                    ram_rd_d = ~wr_d;
                    ram_wr_d = wr_d;
                end
            end
            ACCESS: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // RAM read data is valid now, one cycle after the strobe.
                state_d = RESP;
                if (owner_q == OWN_LDR) begin
                    ldr_done_d = 1'b1;
                    if (!wr_q) ldr_rdata_d = ram_rdata_i;
                end else begin
                    cpu_done_d = 1'b1;
                    if (!wr_q) cpu_rdata_d = ram_rdata_i;
                end
            end
            RESP: begin
                state_d     = IDLE;
                cpu_gnt_d   = 1'b0;
                ldr_gnt_d   = 1'b0;
                ram_addr_d  = '0;
                ram_wdata_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            wr_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_rd_q    <= 1'b0;
            ram_wr_q    <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            ldr_gnt_q   <= 1'b0;
            cpu_done_q  <= 1'b0;
            ldr_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_rd_q    <= ram_rd_d;
            ram_wr_q    <= ram_wr_d;
            cpu_gnt_q   <= cpu_gnt_d;
            ldr_gnt_q   <= ldr_gnt_d;
            cpu_done_q  <= cpu_done_d;
            ldr_done_q  <= ldr_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    assign cpu_gnt_o   = cpu_gnt_q;
    assign cpu_done_o  = cpu_done_q;
    assign cpu_rdata_o = cpu_rdata_q;
    assign ldr_gnt_o   = ldr_gnt_q;
    assign ldr_done_o  = ldr_done_q;
    assign ldr_rdata_o = ldr_rdata_q;
    assign ram_rd_o    = ram_rd_q;
    assign ram_wr_o    = ram_wr_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;

endmodule

`default_nettype wire
